// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined Hack-style ALU:
// control-field indices, named opcodes and a field-extract helper.
package alu_pipe_pkg;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    typedef logic [5:0] alu_op_t;

    localparam alu_op_t ALU_ZERO = 6'b101010;
    localparam alu_op_t ALU_ONE  = 6'b111111;
    localparam alu_op_t ALU_NEG1 = 6'b111010;
    localparam alu_op_t ALU_X    = 6'b001100;
    localparam alu_op_t ALU_Y    = 6'b110000;
    localparam alu_op_t ALU_NOTX = 6'b001101;
    localparam alu_op_t ALU_NOTY = 6'b110001;
    localparam alu_op_t ALU_NEGX = 6'b001111;
    localparam alu_op_t ALU_NEGY = 6'b110011;
    localparam alu_op_t ALU_XINC = 6'b011111;
    localparam alu_op_t ALU_YINC = 6'b110111;
    localparam alu_op_t ALU_XDEC = 6'b001110;
    localparam alu_op_t ALU_YDEC = 6'b110010;
    localparam alu_op_t ALU_ADD  = 6'b000010;
    localparam alu_op_t ALU_SUB  = 6'b010011;
    localparam alu_op_t ALU_RSUB = 6'b000111;
    localparam alu_op_t ALU_AND  = 6'b000000;
    localparam alu_op_t ALU_OR   = 6'b010101;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    function automatic alu_ctrl_t split_ctrl(input alu_op_t op);
        alu_ctrl_t c;
        c.zx = op[CTRL_ZX];
        c.nx = op[CTRL_NX];
        c.zy = op[CTRL_ZY];
        c.ny = op[CTRL_NY];
        c.f  = op[CTRL_F];
        c.no = op[CTRL_NO];
        return c;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Input and output valid/ready bundle of the pipelined ALU.
// master drives operands and out_ready; slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             cy;
    logic             ov;

    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng, cy, ov
    );

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng, cy, ov
    );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational generalised Hack ALU with carry/overflow, exposed as
// independent preset and compute halves so a pipeline can split them.
module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    output logic [WIDTH-1:0] xp,
    output logic [WIDTH-1:0] yp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] xz;
    logic [WIDTH-1:0] yz;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    always_comb begin
        xz = zx ? '0 : x;
        yz = zy ? '0 : y;
        xp = nx ? ~xz : xz;
        yp = ny ? ~yz : yz;
    end

    // One extra adder bit yields the carry out of the MSB.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        r   = f ? sum[MSB:0] : (a & b);
        out = no ? ~r : r;
        zr  = (out == '0);
        ng  = out[MSB];
        cy  = f & sum[WIDTH];
        ov  = f & (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers preset operands, stage 2
// registers the result and flags; valid/ready on both sides.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       reset,
    alu_pipe_if.slave bus
);
    alu_ctrl_t        c_in;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] xp_q, xp_d;
    logic [WIDTH-1:0] yp_q, yp_d;
    logic             f_q, f_d;
    logic             no_q, no_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             cy_q, cy_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] xp_c, yp_c, out_c;
    logic             zr_c, ng_c, cy_c, ov_c;

    logic             s2_adv, s1_adv, in_ready, in_fire;

    assign c_in = split_ctrl(bus.ctrl);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .x   (bus.x),
        .y   (bus.y),
        .zx  (c_in.zx),
        .nx  (c_in.nx),
        .zy  (c_in.zy),
        .ny  (c_in.ny),
        .xp  (xp_c),
        .yp  (yp_c),
        .a   (xp_q),
        .b   (yp_q),
        .f   (f_q),
        .no  (no_q),
        .out (out_c),
        .zr  (zr_c),
        .ng  (ng_c),
        .cy  (cy_c),
        .ov  (ov_c)
    );

    // in_ready depends only on pipe state and out_ready, never on in_valid.
    always_comb begin
        s2_adv   = !s2_valid_q || bus.out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = !s1_valid_q || s2_adv;
        in_fire  = bus.in_valid && in_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        xp_d       = xp_q;
        yp_d       = yp_q;
        f_d        = f_q;
        no_d       = no_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            xp_d = xp_c;
            yp_d = yp_c;
            f_d  = c_in.f;
            no_d = c_in.no;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        zr_d       = zr_q;
        ng_d       = ng_q;
        cy_d       = cy_q;
        ov_d       = ov_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            out_d = out_c;
            zr_d  = zr_c;
            ng_d  = ng_c;
            cy_d  = cy_c;
            ov_d  = ov_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            xp_q       <= '0;
            yp_q       <= '0;
            f_q        <= 1'b0;
            no_q       <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            cy_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            xp_q       <= xp_d;
            yp_q       <= yp_d;
            f_q        <= f_d;
            no_q       <= no_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
            cy_q       <= cy_d;
            ov_q       <= ov_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.cy        = cy_q;
    assign bus.ov        = ov_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 16-bit ops, flags, backpressure,
// mid-flight reset, and an 8-bit instance for the width corner.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    alu_pipe_if #(.WIDTH(16)) bus16 ();
    alu_pipe_if #(.WIDTH(8))  bus8 ();

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_op_t sw_op [18] = '{
        ALU_ZERO, ALU_ONE, ALU_NEG1, ALU_X, ALU_Y, ALU_NOTX,
        ALU_NOTY, ALU_NEGX, ALU_NEGY, ALU_XINC, ALU_YINC, ALU_XDEC,
        ALU_YDEC, ALU_ADD, ALU_SUB, ALU_RSUB, ALU_AND, ALU_OR
    };
    // x=0x0000, y=0xFFFF
    logic [15:0] sw_exp_a [18] = '{
        16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF,
        16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF,
        16'hFFFE, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF
    };
    // x=0x0011, y=0x0003
    logic [15:0] sw_exp_b [18] = '{
        16'h0000, 16'h0001, 16'hFFFF, 16'h0011, 16'h0003, 16'hFFEE,
        16'hFFFC, 16'hFFEF, 16'hFFFD, 16'h0012, 16'h0004, 16'h0010,
        16'h0002, 16'h0014, 16'h000E, 16'hFFF2, 16'h0001, 16'h0013
    };
    logic [15:0] bp_exp [4] = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op into the idle 16-bit pipe; res = {out,zr,ng,cy,ov}.
    task automatic run_op(input logic [15:0] xa, input logic [15:0] ya,
                          input alu_op_t op, output logic [19:0] res,
                          output int lat);
        @(negedge clk);
        bus16.x         = xa;
        bus16.y         = ya;
        bus16.ctrl      = op;
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b1;
        lat = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            bus16.in_valid = 1'b0;
            lat++;
        end while (!bus16.out_valid && lat < 10);
        res = {bus16.out, bus16.zr, bus16.ng, bus16.cy, bus16.ov};
    endtask

    initial begin
        logic [19:0] res;
        logic [11:0] res8;
        int          lat;
        int          issued;
        int          gaps;
        int          unstable;
        logic        acc;
        logic [15:0] rx [$];
        logic [15:0] got;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        bus16.x = '0;
        bus16.y = '0;
        bus16.ctrl = ALU_ZERO;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        bus8.x = '0;
        bus8.y = '0;
        bus8.ctrl = ALU_ZERO;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus16.in_ready), 32'd1);
        chk("rst_result",
            32'({bus16.out, bus16.zr, bus16.ng, bus16.cy, bus16.ov}), 32'd0);
        chk("rst8_result",
            32'({bus8.out_valid, bus8.out, bus8.zr, bus8.ng, bus8.cy, bus8.ov}),
            32'd0);

        run_op(16'h0011, 16'h0003, ALU_ADD, res, lat);
        chk("add_lat", 32'(lat), 32'd2);
        chk("add_res", 32'(res), 32'({16'h0014, 4'b0000}));
        run_op(16'h0011, 16'h0003, ALU_SUB, res, lat);
        chk("sub_res", 32'(res), 32'({16'h000E, 4'b0000}));
        run_op(16'h0011, 16'h0003, ALU_RSUB, res, lat);
        chk("rsub_res", 32'(res), 32'({16'hFFF2, 4'b0110}));

        run_op(16'h7FFF, 16'h0001, ALU_ADD, res, lat);
        chk("ovf_res", 32'(res), 32'({16'h8000, 4'b0101}));
        run_op(16'hFFFF, 16'h0001, ALU_ADD, res, lat);
        chk("carry_res", 32'(res), 32'({16'h0000, 4'b1010}));

        for (int i = 0; i < 18; i++) begin
            run_op(16'h0000, 16'hFFFF, sw_op[i], res, lat);
            chk($sformatf("sweepA_%0d", i), 32'(res[19:4]), 32'(sw_exp_a[i]));
            run_op(16'h0011, 16'h0003, sw_op[i], res, lat);
            chk($sformatf("sweepB_%0d", i), 32'(res[19:4]), 32'(sw_exp_b[i]));
        end

        issued   = 0;
        gaps     = 0;
        unstable = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            bus16.out_ready = (cyc >= 5);
            bus16.in_valid  = (issued < 4);
            bus16.x         = 16'(issued + 1);
            bus16.y         = 16'h0010;
            bus16.ctrl      = ALU_ADD;
            #1;
            if (cyc >= 2 && cyc < 5 && bus16.out !== 16'h0011) unstable++;
            if (cyc == 4) begin
                chk("bp_accepted", 32'(issued), 32'd2);
                chk("bp_in_ready", 32'(bus16.in_ready), 32'd0);
                chk("bp_out_valid", 32'(bus16.out_valid), 32'd1);
            end
            if (bus16.out_valid && bus16.out_ready) rx.push_back(bus16.out);
            else if (rx.size() > 0 && rx.size() < 4) gaps++;
            acc = bus16.in_valid && bus16.in_ready;
            @(posedge clk);
            if (acc) issued++;
        end
        bus16.in_valid = 1'b0;
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_issued", 32'(issued), 32'd4);
        chk("bp_count", 32'(rx.size()), 32'd4);
        chk("bp_gaps", 32'(gaps), 32'd0);
        for (int i = 0; i < 4; i++) begin
            got = (i < rx.size()) ? rx[i] : 16'hDEAD;
            chk($sformatf("bp_order_%0d", i), 32'(got), 32'(bp_exp[i]));
        end

        @(negedge clk);
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.x         = 16'h0005;
        bus16.y         = 16'h0005;
        bus16.ctrl      = ALU_ADD;
        @(posedge clk);
        @(negedge clk);
        bus16.x = 16'h0006;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        chk("flush_pre_in_ready", 32'(bus16.in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("flush_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("flush_out", 32'(bus16.out), 32'd0);
        chk("flush_in_ready", 32'(bus16.in_ready), 32'd1);
        reset = 1'b0;
        run_op(16'h0021, 16'h0001, ALU_ADD, res, lat);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_res", 32'(res[19:4]), 32'h0022);

        @(negedge clk);
        bus8.x         = 8'h80;
        bus8.y         = 8'h80;
        bus8.ctrl      = ALU_ADD;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        lat = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            lat++;
        end while (!bus8.out_valid && lat < 10);
        res8 = {bus8.out, bus8.zr, bus8.ng, bus8.cy, bus8.ov};
        chk("w8_lat", 32'(lat), 32'd2);
        chk("w8_res", 32'(res8), 32'({8'h00, 4'b1011}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
